// File: rtl/main_memory_pkg.sv
// Shared types and defaults for the main-memory controller and its storage array.
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DEPTH   = 16384;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_LATENCY = 2;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word storage with per-byte-lane write enables and a registered read port.
module mem_byte_array
    import main_memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: no reset here on purpose -- a reset would turn the array into flops;
    // the controller masks rdata until a real read has been sampled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Valid/ready main-memory controller with fixed access latency.
// Optional address checking and the rsp_err port are enabled by MEM_ADDR_CHECK_EN.
module main_memory_ctrl
    import main_memory_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                rsp_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [IDX_W:0] DEPTH_I = (IDX_W + 1)'(DEPTH);

    if (DATA_W % 8 != 0) begin : g_err_data_w
        $error("main_memory_ctrl: DATA_W must be a multiple of 8");
    end
    if (LATENCY < 1) begin : g_err_latency
        $error("main_memory_ctrl: LATENCY must be at least 1");
    end
    if (longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_err_depth
        $error("main_memory_ctrl: DEPTH exceeds the ADDR_W address space");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_ok_q, rd_ok_d;
    logic [IDX_W-1:0]  idx;
    logic              idx_ok;
    logic              addr_ok;
    logic              accept;
    logic [DATA_W-1:0] mem_rdata;

    assign idx    = req_addr[IDX_W-1:0];
    assign idx_ok = {1'b0, idx} < DEPTH_I;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
    logic err_q, err_d;

    // Full-address check: aliases above DEPTH are errors, not wrapped indices.
    assign addr_ok = ({1'b0, req_addr} < DEPTH_A) && idx_ok;
    assign rsp_err = err_q;
`else
    logic addr_hi_unused;

    assign addr_ok        = idx_ok;
    assign addr_hi_unused = |req_addr;
`endif

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_ok_d = rd_ok_q;
`ifdef MEM_ADDR_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_ok_d = !req_write && addr_ok;
`ifdef MEM_ADDR_CHECK_EN
                    err_d   = !addr_ok;
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_ok_q <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_ok_q <= rd_ok_d;
`ifdef MEM_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    mem_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .wr_en (accept && req_write && addr_ok),
        .rd_en (accept && !req_write && addr_ok),
        .idx   (idx),
        .be    (req_be),
        .wdata (req_wdata),
        .rdata (mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    // Writes, dropped reads and the reset state all present zero data.
    assign rsp_rdata = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench: three controller instances (default, LATENCY=1, DEPTH=1000).
module tb_main_memory_ctrl;

    localparam int N_DUT = 3;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc_edge;
        bit          period;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be    = '0;
    logic [1:0]  sel       = 2'd0;

    logic        req_valid_v [N_DUT];
    logic        req_ready_v [N_DUT];
    logic        rsp_valid_v [N_DUT];
    logic        rsp_err_v   [N_DUT];
    logic [15:0] rsp_rdata_v [N_DUT];

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [15:0] m_rsp_rdata;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    assign req_valid_v[0] = req_valid && (sel == 2'd0);
    assign req_valid_v[1] = req_valid && (sel == 2'd1);
    assign req_valid_v[2] = req_valid && (sel == 2'd2);

    assign m_req_ready = req_ready_v[sel];
    assign m_rsp_valid = rsp_valid_v[sel];
    assign m_rsp_err   = rsp_err_v[sel];
    assign m_rsp_rdata = rsp_rdata_v[sel];

`ifndef MEM_ADDR_CHECK_EN
    assign rsp_err_v[0] = 1'b0;
    assign rsp_err_v[1] = 1'b0;
    assign rsp_err_v[2] = 1'b0;
`endif

    main_memory_ctrl u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[0])
`ifdef MEM_ADDR_CHECK_EN
        , .rsp_err(rsp_err_v[0])
`endif
    );

    main_memory_ctrl #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[1])
`ifdef MEM_ADDR_CHECK_EN
        , .rsp_err(rsp_err_v[1])
`endif
    );

    main_memory_ctrl #(.DEPTH(1000)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[2])
`ifdef MEM_ADDR_CHECK_EN
        , .rsp_err(rsp_err_v[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd1) ? 1 : 2;
    endfunction

    // Called and returns at posedge+1; the request is accepted on the first edge that sees req_ready.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] exp_rd, input logic exp_err,
                         input bit period);
        int n = 0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        while (!m_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept", {31'd0, m_req_ready}, 32'd1);
        if (m_req_ready) begin
            sb.push_back('{rdata: exp_rd, err: exp_err, acc_edge: cyc + 1, period: period});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Asynchronous reset in the middle of the cycle; outputs must react without an edge.
    task automatic reset_now();
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("rst_rsp_valid", {31'd0, m_rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, m_req_ready}, 32'd1);
        check("rst_rsp_rdata", {16'd0, m_rsp_rdata}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compares every presented response against the queue head.
    initial begin
        exp_t e;
        int   last_rise = 0;
        bit   prev_valid = 1'b0;
        bit   hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                hs_prev    = 1'b0;
                continue;
            end
            if (hs_prev) check("ready_after_hs", {31'd0, m_req_ready}, 32'd1);
            hs_prev = 1'b0;
            if (m_rsp_valid) begin
                check("ready_low_in_resp", {31'd0, m_req_ready}, 32'd0);
                check("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    if (!prev_valid) begin
                        check("latency", cyc + 1 - e.acc_edge, lat_of(sel));
                        if (e.period) check("rsp_period", cyc - last_rise, 32'd2);
                        last_rise = cyc;
                    end
                    check("rsp_rdata", {16'd0, m_rsp_rdata}, {16'd0, e.rdata});
                    check("rsp_err", {31'd0, m_rsp_err}, {31'd0, e.err});
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        hs_prev = 1'b1;
                    end
                end
            end
            prev_valid = m_rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tbl [4];
        int n;
        tbl = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};

        #1;
        for (int i = 0; i < N_DUT; i++) begin
            check("reset_req_ready", {31'd0, req_ready_v[i]}, 32'd1);
            check("reset_rsp_valid", {31'd0, rsp_valid_v[i]}, 32'd0);
            check("reset_rsp_rdata", {16'd0, rsp_rdata_v[i]}, 32'd0);
            check("reset_rsp_err",   {31'd0, rsp_err_v[i]},   32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Default instance: full write/read, byte lanes, be=00 no-op.
        sel = 2'd0;
        issue(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0);
        issue(1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000, 1'b0, 1'b0);
        issue(1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34, 1'b0, 1'b0);
        issue(1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34, 1'b0, 1'b0);
        drain();

        // Backpressure, with a competing write held on the request channel.
        rsp_ready = 1'b0;
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0);
        req_write = 1'b1;
        req_addr  = 16'h0010;
        req_wdata = 16'hDEAD;
        req_be    = 2'b11;
        req_valid = 1'b1;
        n = 0;
        while (!m_rsp_valid && n < 20) begin
            check("busy_ready_low", {31'd0, m_req_ready}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", {31'd0, m_rsp_valid}, 32'd1);
        repeat (5) begin
            check("bp_valid_hold", {31'd0, m_rsp_valid}, 32'd1);
            check("bp_ready_low", {31'd0, m_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_ready_after", {31'd0, m_req_ready}, 32'd1);
        drain();
        issue(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1'b0);
        drain();

        // Reset mid-operation; committed writes survive.
        issue(1'b1, 16'h0040, 16'hCAFE, 2'b11, 16'h0000, 1'b0, 1'b0);
        drain();
        issue(1'b0, 16'h0040, 16'h0000, 2'b00, 16'hCAFE, 1'b0, 1'b0);
        reset_now();
        issue(1'b1, 16'h0050, 16'h7777, 2'b11, 16'h0000, 1'b0, 1'b0);
        reset_now();
        issue(1'b0, 16'h0040, 16'h0000, 2'b00, 16'hCAFE, 1'b0, 1'b0);
        issue(1'b0, 16'h0050, 16'h0000, 2'b00, 16'h7777, 1'b0, 1'b0);
        drain();

        // LATENCY=1: back-to-back reads, one response every two cycles.
        sel = 2'd1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 16'(i), tbl[i], 2'b11, 16'h0000, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 16'(i), 16'h0000, 2'b00, tbl[i], 1'b0, i != 0);
        end
        drain();

        // DEPTH=1000: out-of-range and aliased addresses.
        sel = 2'd2;
        issue(1'b1, 16'd1000, 16'h5555, 2'b11, 16'h0000, CHK, 1'b0);
        issue(1'b0, 16'd1000, 16'h0000, 2'b00, 16'h0000, CHK, 1'b0);
        issue(1'b1, 16'd999,  16'h0999, 2'b11, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'd999,  16'h0000, 2'b00, 16'h0999, 1'b0, 1'b0);
        issue(1'b1, 16'd5,    16'h0505, 2'b11, 16'h0000, 1'b0, 1'b0);
        issue(1'b0, 16'd1029, 16'h0000, 2'b00, CHK ? 16'h0000 : 16'h0505, CHK, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
